// File: rtl/tf_horizontal_tx_pkg.sv
// Shared definitions for the horizontal twiddle link: strobe encodings,
// transmitter FSM states and the reset value of a twiddle entry.
package tf_horizontal_tx_pkg;

  typedef enum logic [1:0] {
    ROM_W_IDLE = 2'd0,
    ROM_W_HI   = 2'd1,
    ROM_W_LO   = 2'd2
  } rom_w_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2,
    DONE    = 2'd3
  } tf_state_e;

  localparam logic [127:0] TF_RESET_ENTRY = 128'h0000000000000001_0000000000000001;

endpackage

// File: rtl/tf_horizontal_tx.sv
// Streams a 4-entry twiddle buffer onto the horizontal link as four
// high-half beats followed by four low-half beats, then pulses done.
module tf_horizontal_tx
  import tf_horizontal_tx_pkg::*;
#(
  parameter int P_WIDTH         = 128,
  parameter int horizontal_DW   = 64,
  parameter int init_store_data = 4
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [1:0]               load_idx,
  input  logic [P_WIDTH-1:0]       load_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               ROM_w,
  output logic [horizontal_DW-1:0] horizontal_tf_out
);

  logic [P_WIDTH-1:0]       entry_q [init_store_data];
  tf_state_e                state_q;
  logic [1:0]               cnt_q;
  logic [1:0]               cnt_inc;
  rom_w_e                   rom_w_q;
  logic [horizontal_DW-1:0] data_q;
  logic                     busy_q;
  logic                     done_q;

  function automatic logic [horizontal_DW-1:0] hi_of(input logic [P_WIDTH-1:0] e);
    return e[P_WIDTH-1 -: horizontal_DW];
  endfunction

  function automatic logic [horizontal_DW-1:0] lo_of(input logic [P_WIDTH-1:0] e);
    return e[horizontal_DW-1:0];
  endfunction

  // Loads are only taken while idle and not starting, so the buffer is
  // frozen for the whole transfer.
  assign load_ready = (state_q == IDLE) && !start;
  assign cnt_inc    = cnt_q + 2'd1;

  // NOTE: the buffer is plain flops, so it can and must take the reset
  // constant; a RAM macro here would leave stale entries after reset.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < init_store_data; i++) entry_q[i] <= P_WIDTH'(TF_RESET_ENTRY);
    end else if (load_valid && load_ready) begin
      entry_q[load_idx] <= load_data;
    end
  end

  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, so state, counter and outputs move together.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rom_w_q <= ROM_W_IDLE;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q   <= 2'd0;
          rom_w_q <= ROM_W_IDLE;
          data_q  <= '0;
          if (start) begin
            state_q <= SEND_HI;
            rom_w_q <= ROM_W_HI;
            data_q  <= hi_of(entry_q[0]);
            busy_q  <= 1'b1;
          end
        end
        SEND_HI: begin
          if (cnt_q == 2'd3) begin
            state_q <= SEND_LO;
            cnt_q   <= 2'd0;
            rom_w_q <= ROM_W_LO;
            data_q  <= lo_of(entry_q[0]);
          end else begin
            cnt_q  <= cnt_inc;
            data_q <= hi_of(entry_q[cnt_inc]);
          end
        end
        SEND_LO: begin
          if (cnt_q == 2'd3) begin
            state_q <= DONE;
            cnt_q   <= 2'd0;
            rom_w_q <= ROM_W_IDLE;
            data_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_inc;
            data_q <= lo_of(entry_q[cnt_inc]);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ROM_w             = rom_w_q;
  assign horizontal_tf_out = data_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule
